// File: rtl/inst_loader_if.sv
// Byte-stream and instruction-RAM write bus of the boot loader.
// The loader uses the slave modport; the host/link side uses master.
interface inst_loader_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic              cpu_hold;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, cpu_hold
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, cpu_hold
    );
endinterface

// File: rtl/inst_loader.sv
// Boot loader: assembles a little-endian word stream into instruction RAM writes.
// Define INST_LOADER_CKSUM_EN to require a trailing 32-bit checksum of all words.
module inst_loader #(
    parameter int unsigned SIZE   = 1024,
    parameter int unsigned ADDR_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    inst_loader_if.slave bus
);

    localparam int unsigned IDX_W  = $clog2(SIZE + 1);
    localparam logic [31:0] SIZE_W = 32'(SIZE);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
`ifdef INST_LOADER_CKSUM_EN
        ,
        S_CKSUM = 3'd6
`endif
    } state_e;

    state_e            state_q,      state_d;
    logic [1:0]        byte_cnt_q,   byte_cnt_d;
    logic [31:0]       shift_q,      shift_d;
    logic [31:0]       words_left_q, words_left_d;
    logic [IDX_W-1:0]  idx_q,        idx_d;
    logic              in_ready_q,   in_ready_d;
    logic              mem_we_q,     mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic [31:0]       mem_wdata_q,  mem_wdata_d;
    logic              busy_q,       busy_d;
    logic              done_q,       done_d;
    logic              err_q,        err_d;
`ifdef INST_LOADER_CKSUM_EN
    logic [31:0]       sum_q,        sum_d;
`endif

    logic        xfer;
    logic        last_byte;
    logic [31:0] full_word;

    assign xfer      = bus.in_valid & in_ready_q;
    assign last_byte = xfer && (byte_cnt_q == 2'd3);
    // Bytes arrive LSB first, so shifting in at the top leaves byte0 in [7:0].
    assign full_word = {bus.in_data, shift_q[31:8]};

    always_comb begin
        // NOTE: every _d starts from its _q (or a fixed value) so no branch leaves a latch.
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        shift_d      = shift_q;
        words_left_d = words_left_q;
        idx_d        = idx_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        done_d       = done_q;
        err_d        = err_q;
`ifdef INST_LOADER_CKSUM_EN
        sum_d        = sum_q;
`endif

        if (xfer) begin
            shift_d    = full_word;
            byte_cnt_d = byte_cnt_q + 2'd1;
        end

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.start) begin
                    state_d    = S_LEN;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    idx_d      = '0;
                    byte_cnt_d = '0;
`ifdef INST_LOADER_CKSUM_EN
                    sum_d      = '0;
`endif
                end
            end
            S_LEN: begin
                if (last_byte) begin
                    if (full_word == '0) begin
`ifdef INST_LOADER_CKSUM_EN
                        state_d = S_CKSUM;
`else
                        state_d = S_DONE;
                        done_d  = 1'b1;
`endif
                    end else if (full_word > SIZE_W) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d      = S_DATA;
                        words_left_d = full_word;
                    end
                end
            end
            S_DATA: begin
                if (last_byte) begin
                    state_d      = S_WRITE;
                    mem_we_d     = 1'b1;
                    mem_addr_d   = ADDR_W'(idx_q) << 2;
                    mem_wdata_d  = full_word;
                    idx_d        = idx_q + IDX_W'(1);
                    words_left_d = words_left_q - 32'd1;
`ifdef INST_LOADER_CKSUM_EN
                    sum_d        = sum_q + full_word;
`endif
                end
            end
            S_WRITE: begin
                if (words_left_q != '0) begin
                    state_d = S_DATA;
                end else begin
`ifdef INST_LOADER_CKSUM_EN
                    state_d = S_CKSUM;
`else
                    state_d = S_DONE;
                    done_d  = 1'b1;
`endif
                end
            end
`ifdef INST_LOADER_CKSUM_EN
            S_CKSUM: begin
                if (last_byte) begin
                    if (full_word == sum_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Handshake flags are registered from the next state so they line up with it.
        in_ready_d = (state_d == S_LEN) || (state_d == S_DATA);
`ifdef INST_LOADER_CKSUM_EN
        if (state_d == S_CKSUM) in_ready_d = 1'b1;
`endif
        busy_d = in_ready_d || (state_d == S_WRITE);
    end

    // NOTE: reset is sampled on the clock edge and clears every flop, including the data registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            byte_cnt_q   <= '0;
            shift_q      <= '0;
            words_left_q <= '0;
            idx_q        <= '0;
            in_ready_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef INST_LOADER_CKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            words_left_q <= words_left_d;
            idx_q        <= idx_d;
            in_ready_q   <= in_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
`ifdef INST_LOADER_CKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.cpu_hold  = busy_q;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: stream-level model of expected RAM writes
// plus directed load scenarios with literal expectations.
`timescale 1ns/1ps
module tb_inst_loader;

    localparam int SIZE = 1024;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    inst_loader_if #(.ADDR_W(32)) bus();

    inst_loader #(.SIZE(SIZE), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Image being loaded and the number of words the loader should write for it.
    logic [31:0] img [SIZE];
    int          exp_nw = 0;
    bit          mon_en = 1'b0;

    int          bcount = 0;
    bit          pend_we = 1'b0;
    logic [31:0] model_addr = '0;
    logic [31:0] model_data = '0;
    int          n_stall = 0;
    int          n_xfer  = 0;
    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: byte b (1-based, counted from start) that completes data word i=b/4-2
    // must produce a write of img[i] at byte address 4*i in the following cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            check("mem_we", 32'(bus.mem_we), 32'(pend_we));
            check("mem_addr", bus.mem_addr, model_addr);
            check("mem_wdata", bus.mem_wdata, model_data);
            check("cpu_hold_eq_busy", 32'(bus.cpu_hold), 32'(bus.busy));
            check("done_err_exclusive", 32'(bus.done & bus.err), 32'(0));
            if (pend_we) check("in_ready_during_write", 32'(bus.in_ready), 32'(0));
            if (bus.mem_we === 1'b1) begin
                log_addr.push_back(bus.mem_addr);
                log_data.push_back(bus.mem_wdata);
            end
            if (bus.busy && !bus.in_ready) n_stall++;
        end
        pend_we = 1'b0;
        if (!rst) begin
            bcount     = 0;
            model_addr = '0;
            model_data = '0;
        end else if (bus.start && !bus.busy) begin
            bcount = 0;
        end else if (bus.in_valid && bus.in_ready) begin
            bcount++;
            n_xfer++;
            if (bcount > 4 && bcount % 4 == 0 && bcount <= 4 + 4 * exp_nw) begin
                pend_we    = 1'b1;
                model_addr = 32'((bcount / 4 - 2) * 4);
                model_data = img[bcount / 4 - 2];
            end
        end
    end

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int guard = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(negedge clk);
        while (!bus.in_ready && guard < 20) begin
            guard++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_err++;
            $display("FAIL byte_accept: in_ready still 0 after %0d cycles, required 1", guard);
        end
        @(posedge clk); #1;
        if (gap) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
    endtask

    task automatic wait_idle();
        int g = 0;
        while (bus.busy && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        if (bus.busy) begin
            n_checks++;
            n_err++;
            $display("FAIL wait_idle: busy=%0b after %0d cycles, required 0", bus.busy, g);
        end
    endtask

    task automatic load_image(input int n, input bit gap, input logic [31:0] cks_flip);
        logic [31:0] sum;
        sum    = '0;
        exp_nw = n;
        pulse_start();
        send_word(32'(n), gap);
        for (int i = 0; i < n; i++) begin
            send_word(img[i], gap);
            sum = sum + img[i];
        end
`ifdef INST_LOADER_CKSUM_EN
        send_word(sum ^ cks_flip, gap);
`else
        if (cks_flip != '0) sum = sum ^ cks_flip;
`endif
        bus.in_valid = 1'b0;
        wait_idle();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'(0));
        check({tag, "_mem_we"}, 32'(bus.mem_we), 32'(0));
        check({tag, "_mem_addr"}, bus.mem_addr, 32'(0));
        check({tag, "_mem_wdata"}, bus.mem_wdata, 32'(0));
        check({tag, "_busy"}, 32'(bus.busy), 32'(0));
        check({tag, "_done"}, 32'(bus.done), 32'(0));
        check({tag, "_err"}, 32'(bus.err), 32'(0));
        check({tag, "_cpu_hold"}, 32'(bus.cpu_hold), 32'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, x0, exp_x;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        rst          = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        check_all_zero("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        // 1) two-word image with idle gaps between bytes
        img[0] = 32'h0000_0513;
        img[1] = 32'h0000_006F;
        log_addr.delete(); log_data.delete();
        load_image(2, 1'b1, '0);
        check("t1_done", 32'(bus.done), 32'(1));
        check("t1_err", 32'(bus.err), 32'(0));
        check("t1_busy", 32'(bus.busy), 32'(0));
        check("t1_nwrites", 32'(log_addr.size()), 32'(2));
        if (log_addr.size() == 2) begin
            check("t1_addr0", log_addr[0], 32'h0);
            check("t1_data0", log_data[0], 32'h0000_0513);
            check("t1_addr1", log_addr[1], 32'h4);
            check("t1_data1", log_data[1], 32'h0000_006F);
        end

        // 2) empty image
        log_addr.delete(); log_data.delete();
        exp_nw = 0;
        pulse_start();
        check("t2_busy_after_start", 32'(bus.busy), 32'(1));
        send_word(32'h0, 1'b0);
`ifdef INST_LOADER_CKSUM_EN
        send_word(32'h0, 1'b0);
`endif
        bus.in_valid = 1'b0;
        check("t2_done", 32'(bus.done), 32'(1));
        check("t2_cpu_hold", 32'(bus.cpu_hold), 32'(0));
        check("t2_nwrites", 32'(log_addr.size()), 32'(0));

        // 3) length one above SIZE
        exp_nw = 0;
        pulse_start();
        send_word(32'h0000_0401, 1'b0);
        bus.in_valid = 1'b0;
        check("t3_err", 32'(bus.err), 32'(1));
        check("t3_done", 32'(bus.done), 32'(0));
        check("t3_in_ready", 32'(bus.in_ready), 32'(0));
        check("t3_busy", 32'(bus.busy), 32'(0));
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAA;
        repeat (3) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("t3_in_ready_held", 32'(bus.in_ready), 32'(0));
        check("t3_nwrites", 32'(log_addr.size()), 32'(0));
        pulse_start();
        check("t3_err_cleared", 32'(bus.err), 32'(0));
        check("t3_restart_busy", 32'(bus.busy), 32'(1));
        send_word(32'h0, 1'b0);
`ifdef INST_LOADER_CKSUM_EN
        send_word(32'h0, 1'b0);
`endif
        bus.in_valid = 1'b0;
        wait_idle();
        check("t3_done_after_restart", 32'(bus.done), 32'(1));

        // 4) back-to-back bytes, three words
        img[0] = 32'hDEAD_BEEF;
        img[1] = 32'h0123_4567;
        img[2] = 32'h89AB_CDEF;
        log_addr.delete(); log_data.delete();
        s0 = n_stall;
        x0 = n_xfer;
        exp_x = 16;
`ifdef INST_LOADER_CKSUM_EN
        exp_x = 20;
`endif
        load_image(3, 1'b0, '0);
        check("t4_stall_cycles", 32'(n_stall - s0), 32'(3));
        check("t4_bytes", 32'(n_xfer - x0), 32'(exp_x));
        check("t4_nwrites", 32'(log_addr.size()), 32'(3));
        if (log_addr.size() == 3) begin
            check("t4_addr2", log_addr[2], 32'h8);
            check("t4_data1", log_data[1], 32'h0123_4567);
        end
        check("t4_done", 32'(bus.done), 32'(1));

        // 5) reset in the middle of word 1
        img[0] = 32'h1122_3344;
        img[1] = 32'h5566_7788;
        log_addr.delete(); log_data.delete();
        exp_nw = 2;
        pulse_start();
        send_word(32'h2, 1'b0);
        send_word(img[0], 1'b0);
        send_byte(8'h88, 1'b0);
        send_byte(8'h77, 1'b0);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        check_all_zero("t5_reset");
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("t5_nwrites", 32'(log_addr.size()), 32'(1));
        img[0] = 32'hCAFE_0001;
        img[1] = 32'hCAFE_0002;
        log_addr.delete(); log_data.delete();
        load_image(2, 1'b0, '0);
        check("t5_reload_done", 32'(bus.done), 32'(1));
        check("t5_reload_nwrites", 32'(log_addr.size()), 32'(2));

        // N == SIZE: fills the whole memory, last word at 0xFFC
        for (int i = 0; i < SIZE; i++) img[i] = 32'(i) * 32'h9E37_79B9 + 32'd1;
        log_addr.delete(); log_data.delete();
        load_image(SIZE, 1'b0, '0);
        check("full_done", 32'(bus.done), 32'(1));
        check("full_nwrites", 32'(log_addr.size()), 32'(SIZE));
        if (log_addr.size() == SIZE) begin
            check("full_last_addr", log_addr[SIZE-1], 32'h0000_0FFC);
            check("full_last_data", log_data[SIZE-1], img[SIZE-1]);
        end

`ifdef INST_LOADER_CKSUM_EN
        // 6) checksum: 0x1 + 0xFFFFFFFF wraps to 0
        img[0] = 32'h0000_0001;
        img[1] = 32'hFFFF_FFFF;
        log_addr.delete(); log_data.delete();
        load_image(2, 1'b0, '0);
        check("t6_good_done", 32'(bus.done), 32'(1));
        check("t6_good_err", 32'(bus.err), 32'(0));
        load_image(2, 1'b0, 32'h0000_0001);
        check("t6_bad_err", 32'(bus.err), 32'(1));
        check("t6_bad_done", 32'(bus.done), 32'(0));
        check("t6_nwrites", 32'(log_addr.size()), 32'(4));
`endif

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
